// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle controller and the datapath.
// master = controller side, slave = datapath side.
interface multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       op;
  logic [5:0]       fun;
  logic             alu_zero;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_we;
  logic             iord;
  logic             ir_we;
  logic             pc_we;
  logic [1:0]       pc_src;
  logic             reg_we;
  logic [1:0]       reg_dst;
  logic [1:0]       mem_to_reg;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic             ext_sign;
  logic [3:0]       alu_ctrl;
  logic             illegal;
  logic             bus_err;
  logic [2:0]       state;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    input  op, fun, alu_zero, mem_ready,
    output mem_req, mem_we, iord, ir_we, pc_we, pc_src,
    output reg_we, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
    output ext_sign, alu_ctrl, illegal, bus_err, state, instr_cnt
  );

  modport slave (
    output op, fun, alu_zero, mem_ready,
    input  mem_req, mem_we, iord, ir_we, pc_we, pc_src,
    input  reg_we, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
    input  ext_sign, alu_ctrl, illegal, bus_err, state, instr_cnt
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle CPU main control FSM with retired-instruction counter.
// Optional memory wait timeout: define MEM_TIMEOUT_EN.
module multicycle_ctrl #(
  parameter int         CNT_W   = 32,
  parameter logic [5:0] HALT_OP = 6'h3F,
  parameter int         TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_e;

  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2;
  localparam logic [3:0] A_OR  = 4'd3, A_SLT = 4'd4, A_SLL = 4'd5;
  localparam logic [3:0] A_SRL = 4'd6, A_LUI = 4'd7;
  localparam int WW = $clog2(TIMEOUT + 1);

`ifdef MEM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             illegal_q, illegal_d;
  logic             bus_err_q, bus_err_d;
  logic [WW-1:0]    wait_q, wait_d;

  logic [5:0] op, fun;
  logic is_r, r_alu, is_jr, is_j, is_jal;
  logic is_addi, is_andi, is_ori, is_lui;
  logic is_lw, is_sw, is_beq, is_bne, legal;
  logic waiting, to_hit, cnt_inc;
  logic [3:0] r_ctrl;

  assign op  = bus.op;
  assign fun = bus.fun;

  assign is_r    = (op == 6'h00);
  assign is_jr   = is_r && (fun == 6'h08);
  assign r_alu   = is_r && (fun == 6'h20 || fun == 6'h22 ||
                            fun == 6'h24 || fun == 6'h25 ||
                            fun == 6'h2A || fun == 6'h00 ||
                            fun == 6'h02);
  assign is_j    = (op == 6'h02);
  assign is_jal  = (op == 6'h03);
  assign is_addi = (op == 6'h08);
  assign is_andi = (op == 6'h0C);
  assign is_ori  = (op == 6'h0D);
  assign is_lui  = (op == 6'h0F);
  assign is_lw   = (op == 6'h23);
  assign is_sw   = (op == 6'h2B);
  assign is_beq  = (op == 6'h04);
  assign is_bne  = (op == 6'h05);
  assign legal   = r_alu | is_jr | is_addi | is_andi | is_ori |
                   is_lui | is_lw | is_sw | is_beq | is_bne;

  always_comb begin
    r_ctrl = A_ADD;
    case (fun)
      6'h22:   r_ctrl = A_SUB;
      6'h24:   r_ctrl = A_AND;
      6'h25:   r_ctrl = A_OR;
      6'h2A:   r_ctrl = A_SLT;
      6'h00:   r_ctrl = A_SLL;
      6'h02:   r_ctrl = A_SRL;
      default: r_ctrl = A_ADD;
    endcase
  end

  // Wait counter is built in both configurations but only armed with the feature.
  assign waiting = TO_EN && !bus.mem_ready &&
                   (state_q == FETCH || state_q == MEM);
  assign to_hit  = waiting && (wait_q == WW'(TIMEOUT - 1));
  assign wait_d  = waiting ? wait_q + 1'b1 : '0;

  always_comb begin
    state_d        = state_q;
    illegal_d      = illegal_q;
    bus_err_d      = bus_err_q;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.iord       = 1'b0;
    bus.ir_we      = 1'b0;
    bus.pc_we      = 1'b0;
    bus.pc_src     = 2'd0;
    bus.reg_we     = 1'b0;
    bus.reg_dst    = 2'd0;
    bus.mem_to_reg = 2'd0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'd0;
    bus.ext_sign   = 1'b0;
    bus.alu_ctrl   = A_ADD;
    if (!rst) begin
      unique case (state_q)
        FETCH: begin
          bus.mem_req   = 1'b1;
          bus.alu_src_b = 2'd1;
          if (bus.mem_ready) begin
            bus.ir_we = 1'b1;
            bus.pc_we = 1'b1;
            state_d   = DECODE;
          end else if (to_hit) begin
            bus_err_d = 1'b1;
            state_d   = HALT;
          end
        end
        DECODE: begin
          bus.alu_src_b = 2'd3;
          if (is_j || is_jal) begin
            bus.pc_we  = 1'b1;
            bus.pc_src = 2'd2;
            if (is_jal) begin
              bus.reg_we     = 1'b1;
              bus.reg_dst    = 2'd2;
              bus.mem_to_reg = 2'd2;
            end
            state_d = FETCH;
          end else if (op == HALT_OP) begin
            state_d = HALT;
          end else if (!legal) begin
            illegal_d = 1'b1;
            state_d   = HALT;
          end else begin
            state_d = EXEC;
          end
        end
        EXEC: begin
          bus.alu_src_a = 1'b1;
          state_d       = FETCH;
          unique case (1'b1)
            r_alu: begin
              bus.alu_ctrl = r_ctrl;
              state_d      = WB;
            end
            is_jr: begin
              bus.alu_src_a = 1'b0;
              bus.pc_we     = 1'b1;
              bus.pc_src    = 2'd3;
            end
            is_addi, is_andi, is_ori, is_lui: begin
              bus.alu_src_b = 2'd2;
              bus.ext_sign  = is_addi;
              bus.alu_ctrl  = is_andi ? A_AND :
                              is_ori  ? A_OR  :
                              is_lui  ? A_LUI : A_ADD;
              state_d       = WB;
            end
            is_lw, is_sw: begin
              bus.alu_src_b = 2'd2;
              bus.ext_sign  = 1'b1;
              state_d       = MEM;
            end
            is_beq, is_bne: begin
              bus.alu_ctrl = A_SUB;
              bus.pc_src   = 2'd1;
              bus.pc_we    = is_beq ? bus.alu_zero : !bus.alu_zero;
            end
            default: bus.alu_src_a = 1'b0;
          endcase
        end
        MEM: begin
          bus.mem_req = 1'b1;
          bus.iord    = 1'b1;
          bus.mem_we  = is_sw;
          if (bus.mem_ready) begin
            state_d = is_lw ? WB : FETCH;
          end else if (to_hit) begin
            bus_err_d = 1'b1;
            state_d   = HALT;
          end
        end
        WB: begin
          bus.reg_we     = 1'b1;
          bus.reg_dst    = is_r ? 2'd1 : 2'd0;
          bus.mem_to_reg = is_lw ? 2'd1 : 2'd0;
          state_d        = FETCH;
        end
        default: state_d = state_q;
      endcase
    end
  end

  assign cnt_inc = (state_d == FETCH) &&
                   (state_q inside {DECODE, EXEC, MEM, WB});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FETCH;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
      wait_q    <= wait_d;
      if (cnt_inc) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.state     = state_q;
  assign bus.instr_cnt = cnt_q;
  assign bus.illegal   = illegal_q;
  assign bus.bus_err   = bus_err_q;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Main control FSM for the multi-cycle CPU datapath. It takes op/fun from the instruction decoder plus ALU zero and a memory-ready handshake. It sequences fetch, decode, execute, memory and writeback by driving every datapath mux select and write enable. It also keeps a retired-instruction counter and a sticky illegal-opcode flag.

Parameters:
CNT_W, 32, width of retired-instruction counter
HALT_OP, 6'h3F, opcode that parks FSM in HALT
TIMEOUT, 255, max wait cycles on mem_ready (used only with MEM_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
op  in  6  opcode from decoder (IR-held, stable from DECODE onward)
fun  in  6  function field from decoder
alu_zero  in  1  ALU result==0
mem_ready  in  1  memory completes current access this cycle
mem_req  out  1  memory access request
mem_we  out  1  memory write (store)
iord  out  1  address select: 0=PC, 1=ALUOut
ir_we  out  1  instruction register load
pc_we  out  1  PC load
pc_src  out  2  0=ALU result (PC+4), 1=ALUOut (branch target), 2=jump {PC[31:28],imm26,00}, 3=rs (jr)
reg_we  out  1  register file write
reg_dst  out  2  0=rt, 1=rd, 2=r31
mem_to_reg  out  2  0=ALUOut, 1=MDR, 2=PC
alu_src_a  out  1  0=PC, 1=rs
alu_src_b  out  2  0=rt, 1=const 4, 2=ext imm16, 3=sext imm16<<2
ext_sign  out  1  1=sign-extend, 0=zero-extend imm16
alu_ctrl  out  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 SLL, 6 SRL, 7 LUI
illegal  out  1  sticky: unsupported op/fun seen
bus_err  out  1  sticky memory timeout (0 unless MEM_TIMEOUT_EN)
state  out  3  current state (debug)
instr_cnt  out  CNT_W  retired instructions, wraps

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- Reset: state=FETCH, instr_cnt=0, illegal=0, bus_err=0. While rst is high, all control outputs are forced to 0. A reset mid-instruction aborts it with no writes.
- Control outputs are combinational from state/op/fun/alu_zero/mem_ready. Any output not listed for a state is 0.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=1, ADD. If mem_ready=1: ir_we=1, pc_we=1, pc_src=0, go to DECODE. Otherwise hold with mem_req held high. A zero-wait response (mem_ready in the same cycle) is legal.
- DECODE: alu_src_a=0, alu_src_b=3, ADD (branch target into ALUOut). Next state by op:
  - j (02): pc_we, pc_src=2, go to FETCH.
  - jal (03): the same, plus reg_we, reg_dst=2, mem_to_reg=2.
  - HALT_OP: go to HALT.
  - Unsupported op/fun: set illegal, go to HALT.
  - All others: go to EXEC.
- Supported instructions:
  - R-type fun: 20 add, 22 sub, 24 and, 25 or, 2A slt, 00 sll, 02 srl, 08 jr.
  - I-type op: 08 addi, 0C andi, 0D ori, 0F lui, 23 lw, 2B sw, 04 beq, 05 bne.
- EXEC:
  - R-ALU: alu_src_a=1, alu_src_b=0, alu_ctrl from fun, go to WB.
  - jr: pc_we, pc_src=3, go to FETCH.
  - addi/andi/ori/lui: alu_src_a=1, alu_src_b=2. ext_sign=1 only for addi. ALU op ADD/AND/OR/LUI respectively. Go to WB.
  - lw/sw: alu_src_a=1, alu_src_b=2, ext_sign=1, ADD, go to MEM.
  - beq/bne: alu_src_a=1, alu_src_b=0, SUB, pc_src=1. pc_we = alu_zero (beq) or ~alu_zero (bne). Go to FETCH.
- MEM: mem_req=1, iord=1, mem_we=1 for sw. Hold until mem_ready. Then lw goes to WB, sw goes to FETCH.
- WB: reg_we=1. reg_dst=1 for R-type, else 0. mem_to_reg=1 for lw, else 0. Go to FETCH.
- HALT: outputs idle. Leaves only on reset.
- instr_cnt increments by 1 on every clock edge where the state moves to FETCH from DECODE, EXEC, MEM or WB. It wraps from 2^CNT_W-1 to 0.
- CPI with zero-wait memory: j/jal 2, beq/bne/jr 3, R/I-ALU 4, sw 4, lw 5.

Optional Feature:
MEM_TIMEOUT_EN.
- Defined: a wait counter counts consecutive FETCH/MEM cycles with mem_req=1 and mem_ready=0. When it reaches TIMEOUT, bus_err is set (sticky), the FSM goes to HALT, and no write is issued. The counter clears on mem_ready and on reset.
- Undefined: the FSM waits indefinitely and bus_err is tied 0.

Test Plan:
- Reset, then add (op 00, fun 20), zero-wait memory -> states 0,1,2,4,0. reg_we=1 and reg_dst=1 in WB. instr_cnt=1 after 4 cycles.
- lw (op 23) with mem_ready delayed 3 cycles in MEM -> mem_req=1, iord=1 held 4 cycles. Then WB with mem_to_reg=1. instr_cnt increments once.
- beq (op 04) with alu_zero=1, then alu_zero=0 -> pc_we=1 and pc_src=1 in EXEC for the first. pc_we=0 for the second. Each takes 3 cycles.
- jal (op 03) -> in DECODE: pc_we=1, pc_src=2, reg_we=1, reg_dst=2, mem_to_reg=2. Next state FETCH.
- op 3E -> illegal=1 and state=HALT, both held across 10 cycles. Asserting rst clears them and state=FETCH.
- With MEM_TIMEOUT_EN, TIMEOUT=4, mem_ready held 0 in FETCH -> bus_err=1 and HALT after 4 wait cycles. Without the macro, FETCH is still held after 300 cycles.
